// File: rtl/p09_vga_timing_gen_if.sv
// Raster timing bundle: enable and compare line into the generator,
// position, sync, blanking and strobes out to the pixel pipeline and game logic.
interface p09_vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           en;
    logic [Y_W-1:0] cmp_line;
    logic           pix_ce;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           hsync;
    logic           vsync;
    logic           hblank;
    logic           vblank;
    logic           line_start;
    logic           frame_start;
    logic           cmp_irq;

    modport master (
        input  en, cmp_line,
        output pix_ce, x, y, hsync, vsync, hblank, vblank,
               line_start, frame_start, cmp_irq
    );

    modport slave (
        output en, cmp_line,
        input  pix_ce, x, y, hsync, vsync, hblank, vblank,
               line_start, frame_start, cmp_irq
    );
endinterface

// File: rtl/p09_vga_timing_gen.sv
// Parametrised VGA raster generator: divided pixel enable, x/y counters,
// registered sync/blank levels and one-clock line/frame/raster-compare strobes.
module p09_vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV   = 1,
    parameter int          X_W       = 10,
    parameter int          Y_W       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    p09_vga_timing_gen_if.master  vga
);
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_ON = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_OFF = H_SYNC_ON + H_SYNC;
    localparam int unsigned V_SYNC_ON = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_OFF = V_SYNC_ON + V_SYNC;
    localparam int          DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             cmp_irq_q, cmp_irq_d;
    logic             pix_ce;
    logic             x_wrap;
    logic             y_wrap;

    always_comb begin
        pix_ce = !rst && vga.en && (32'(div_q) == CLK_DIV - 1);
        x_wrap = (32'(x_q) == H_TOTAL - 1);
        y_wrap = (32'(y_q) == V_TOTAL - 1);

        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        if (vga.en) begin
            div_d = pix_ce ? '0 : div_q + DIV_W'(1);
        end
        if (pix_ce) begin
            x_d = x_wrap ? '0 : x_q + X_W'(1);
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + Y_W'(1);
            end
        end

        // Levels are decoded from the next position so they line up with x/y.
        hsync_d  = ((32'(x_d) >= H_SYNC_ON) && (32'(x_d) < H_SYNC_OFF)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = ((32'(y_d) >= V_SYNC_ON) && (32'(y_d) < V_SYNC_OFF)) ? VSYNC_POL : ~VSYNC_POL;
        hblank_d = (32'(x_d) >= H_VISIBLE);
        vblank_d = (32'(y_d) >= V_VISIBLE);

        line_start_d  = pix_ce && x_wrap;
        frame_start_d = pix_ce && x_wrap && y_wrap;
        cmp_irq_d     = pix_ce && (32'(x_q) == H_VISIBLE - 1) && (y_q == vga.cmp_line);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            cmp_irq_q     <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            cmp_irq_q     <= cmp_irq_d;
        end
    end

    assign vga.pix_ce      = pix_ce;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.hblank      = hblank_q;
    assign vga.vblank      = vblank_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.cmp_irq     = cmp_irq_q;
endmodule

// File: tb/tb_p09_vga_timing_gen.sv
// Two generators (small 12x7 mode with CLK_DIV=4 and active-high syncs, default 800x525 mode);
// expected snapshots are queued by cycle and a negedge monitor checks them and flags stray strobes.
module tb_p09_vga_timing_gen;
    typedef struct packed {
        int   x;
        int   y;
        logic hs, vs, hb, vb, pce, ls, fs, ci;
    } st_t;

    typedef struct {
        int  c;
        st_t s;
    } snap_t;

    localparam int R  = 5;
    localparam int R3 = R + 975;
    localparam int R2 = R + 2352;

    logic  clk = 1'b0;
    logic  rst_a = 1'b1;
    logic  rst_b = 1'b1;
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    snap_t qa[$];
    snap_t qb[$];

    p09_vga_timing_gen_if #(.X_W(4), .Y_W(3))   ifa ();
    p09_vga_timing_gen_if #(.X_W(10), .Y_W(10)) ifb ();

    p09_vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(4), .X_W(4), .Y_W(3)
    ) dut_a (.clk(clk), .rst(rst_a), .vga(ifa));

    p09_vga_timing_gen dut_b (.clk(clk), .rst(rst_b), .vga(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int d, input int c, input int x, input int y,
                                 input bit hs, input bit vs, input bit hb, input bit vb,
                                 input bit p, input bit ls, input bit fs, input bit ci);
        snap_t e;
        int    i;
        e.c = c;
        e.s.x = x;   e.s.y = y;
        e.s.hs = hs; e.s.vs = vs; e.s.hb = hb; e.s.vb = vb;
        e.s.pce = p; e.s.ls = ls; e.s.fs = fs; e.s.ci = ci;
        i = 0;
        if (d == 0) begin
            while (i < qa.size() && qa[i].c <= c) i++;
            qa.insert(i, e);
        end else begin
            while (i < qb.size() && qb[i].c <= c) i++;
            qb.insert(i, e);
        end
    endfunction

    // Small mode: syncs active high, pix_ce low on line starts (divider at 0).
    function automatic void a_line(input int c, input int y);
        push(0, c, 0, y, 0, y == 5, 0, y >= 4, 0, 1, y == 0, 0);
    endfunction

    function automatic void a_cmp(input int c);
        push(0, c, 8, 2, 0, 0, 1, 0, 0, 0, 0, 1);
    endfunction

    function automatic void b_line(input int c, input int y);
        push(1, c, 0, y, 1, 1, 0, 0, 1, 1, 0, 0);
    endfunction

    function automatic string fmt(input st_t s);
        return $sformatf("x=%0d y=%0d hs=%0b vs=%0b hb=%0b vb=%0b ce=%0b ls=%0b fs=%0b ci=%0b",
                         s.x, s.y, s.hs, s.vs, s.hb, s.vb, s.pce, s.ls, s.fs, s.ci);
    endfunction

    task automatic check(input int d, input st_t o);
        snap_t e;
        bit    have;
        have = 1'b0;
        if (d == 0) begin
            while (qa.size() > 0 && qa[0].c < cyc) begin
                e = qa.pop_front();
                n_tests++; n_fail++;
                $display("FAIL dut%0d missed snapshot: cycle %0d passed, need %s", d, e.c, fmt(e.s));
            end
            if (qa.size() > 0 && qa[0].c == cyc) begin e = qa.pop_front(); have = 1'b1; end
        end else begin
            while (qb.size() > 0 && qb[0].c < cyc) begin
                e = qb.pop_front();
                n_tests++; n_fail++;
                $display("FAIL dut%0d missed snapshot: cycle %0d passed, need %s", d, e.c, fmt(e.s));
            end
            if (qb.size() > 0 && qb[0].c == cyc) begin e = qb.pop_front(); have = 1'b1; end
        end
        if (have) begin
            n_tests++;
            if (o !== e.s) begin
                n_fail++;
                $display("FAIL dut%0d snapshot cyc %0d: got %s ; need %s", d, cyc, fmt(o), fmt(e.s));
            end
        end else if (o.ls || o.fs || o.ci) begin
            n_tests++; n_fail++;
            $display("FAIL dut%0d stray strobe cyc %0d: got ls=%0b fs=%0b ci=%0b, need all 0",
                     d, cyc, o.ls, o.fs, o.ci);
        end
    endtask

    always @(negedge clk) begin
        st_t oa;
        st_t ob;
        oa.x = int'(ifa.x);   oa.y = int'(ifa.y);
        oa.hs = ifa.hsync;    oa.vs = ifa.vsync;
        oa.hb = ifa.hblank;   oa.vb = ifa.vblank;
        oa.pce = ifa.pix_ce;  oa.ls = ifa.line_start;
        oa.fs = ifa.frame_start; oa.ci = ifa.cmp_irq;
        ob.x = int'(ifb.x);   ob.y = int'(ifb.y);
        ob.hs = ifb.hsync;    ob.vs = ifb.vsync;
        ob.hb = ifb.hblank;   ob.vb = ifb.vblank;
        ob.pce = ifb.pix_ce;  ob.ls = ifb.line_start;
        ob.fs = ifb.frame_start; ob.ci = ifb.cmp_irq;
        check(0, oa);
        check(1, ob);
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ifa.en = 1'b1; ifa.cmp_line = 3'd2;
        ifb.en = 1'b1; ifb.cmp_line = 10'd2;

        // Small mode: reset, cold start, two frames, freeze, mid-frame reset, cold restart.
        push(0, 3,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, R,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, R + 3,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        push(0, R + 4,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, R + 32, 8, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(0, R + 36, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        push(0, R + 40, 10, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        push(0, R + 44, 11, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 14; k++) a_line(R + 48 * k, k % 7);
        a_cmp(R + 128);
        a_cmp(R + 464);
        push(0, R + 690, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, R + 703, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        push(0, R + 704, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 15; k <= 19; k++) a_line(R + 20 + 48 * k, k % 7);
        a_cmp(R + 820);
        push(0, R + 973, 10, 5, 1, 1, 1, 1, 0, 0, 0, 0);
        push(0, R + 974, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, R3,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, R3 + 3,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        push(0, R3 + 4,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) a_line(R3 + 48 * k, k % 7);
        a_cmp(R3 + 128);
        push(0, R3 + 340, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Default 800x525 mode: cold start, freeze at x=300, sync/blank edges, reset at x=700.
        push(1, 3,       0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        push(1, R,       0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        push(1, R + 1,   1, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        push(1, R + 299, 299, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        push(1, R + 300, 300, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        push(1, R + 349, 300, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        push(1, R + 350, 300, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        push(1, R + 351, 301, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        push(1, R + 689, 639, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        push(1, R + 690, 640, 0, 1, 1, 1, 0, 1, 0, 0, 0);
        push(1, R + 705, 655, 0, 1, 1, 1, 0, 1, 0, 0, 0);
        push(1, R + 706, 656, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        push(1, R + 801, 751, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        push(1, R + 802, 752, 0, 1, 1, 1, 0, 1, 0, 0, 0);
        b_line(R + 850, 1);
        b_line(R + 1650, 2);
        push(1, R + 2290, 640, 2, 1, 1, 1, 0, 1, 0, 0, 1);
        push(1, R + 2350, 700, 2, 0, 1, 1, 0, 0, 0, 0, 0);
        push(1, R + 2351, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        push(1, R2,       0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        push(1, R2 + 1,   1, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        b_line(R2 + 800, 1);
        b_line(R2 + 1600, 2);
        push(1, R2 + 2240, 640, 2, 1, 1, 1, 0, 1, 0, 0, 0);

        wait_until(R);
        rst_a = 1'b0;
        rst_b = 1'b0;
        wait_until(R + 300);  ifb.en = 1'b0;
        wait_until(R + 350);  ifb.en = 1'b1;
        wait_until(R + 682);  ifa.en = 1'b0;
        wait_until(R + 702);  ifa.en = 1'b1;
        wait_until(R + 973);  rst_a = 1'b1;
        wait_until(R + 975);  rst_a = 1'b0;
        wait_until(R3 + 340); ifa.en = 1'b0;
        wait_until(R + 2350); rst_b = 1'b1;
        wait_until(R2);
        rst_b = 1'b0;
        ifb.cmp_line = 10'd600;
        wait_until(R2 + 2300);

        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL queue drain: got %0d/%0d pending snapshots, need 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
